// File: rtl/ofm_writeback.sv
// ofm_writeback: output-feature writeback stage behind the CLP array.
// Takes Tm-lane beats (in_data qualified by in_valid), applies optional
// per-lane ReLU, packs BPW beats per DATA_BUS_WIDTH word and writes the
// words to consecutive addresses of the selected ping-pong bank. One
// start/descriptor covers one contiguous output tile.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, base_addr, beat_count,
//   bank_sel, relu_en             tile command (honoured only when idle)
//   in_valid, in_data             CLP beat stream, no backpressure
//   wr_en, wr_addr, wr_data,
//   wr_bank                       registered memory write port
//   busy, done                    tile in progress / one-cycle completion
//   beats_written                 beats accepted in current/last tile
//   drop_err                      sticky: beat seen while not accepting
module ofm_writeback #(
  parameter int Tm             = 4,
  parameter int FEATURE_WIDTH  = 16,
  parameter int DATA_BUS_WIDTH = 128,
  parameter int ADDR_WIDTH     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  input  logic [15:0]                 beat_count,
  input  logic                        bank_sel,
  input  logic                        relu_en,
  input  logic                        in_valid,
  input  logic [Tm*FEATURE_WIDTH-1:0] in_data,
  output logic                        wr_en,
  output logic [ADDR_WIDTH-1:0]       wr_addr,
  output logic [DATA_BUS_WIDTH-1:0]   wr_data,
  output logic                        wr_bank,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 beats_written,
  output logic                        drop_err
);
  localparam int BEAT_W = Tm * FEATURE_WIDTH;
  localparam int BPW    = DATA_BUS_WIDTH / BEAT_W;
  localparam int KW     = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH, S_DONE} state_t;
  state_t state, state_nxt;

  // Latched descriptor and packing state
  logic [ADDR_WIDTH-1:0]     waddr;
  logic [15:0]               bc_q;
  logic                      bank_q, relu_q;
  logic [KW-1:0]             k;
  logic [DATA_BUS_WIDTH-1:0] pack;

  logic                      accept, take, last, word_end;
  logic [BEAT_W-1:0]         beat_r;
  logic [DATA_BUS_WIDTH-1:0] pack_nxt;

  assign accept = (state == S_IDLE) && start;
  assign take   = (state == S_COLLECT) && in_valid;
  assign last   = take && ((beats_written + 16'd1) == bc_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = (beat_count == 16'd0) ? S_DONE : S_COLLECT;
      S_COLLECT: if (last)  state_nxt = S_FLUSH;
      S_FLUSH:   state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Beat conditioning and slot insertion; a word closes when the last slot
  // fills or the tile's final beat arrives (leaving upper slots zero).
  always_comb begin
    beat_r = in_data;
    if (relu_q) begin
      for (int l = 0; l < Tm; l++)
        if (in_data[(l+1)*FEATURE_WIDTH-1])
          beat_r[l*FEATURE_WIDTH +: FEATURE_WIDTH] = '0;
    end
    pack_nxt = pack;
    for (int s = 0; s < BPW; s++)
      if (k == KW'(s)) pack_nxt[s*BEAT_W +: BEAT_W] = beat_r;
    word_end = take && ((k == KW'(BPW-1)) || last);
  end

  // Registered datapath and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      waddr         <= '0;
      bc_q          <= '0;
      bank_q        <= 1'b0;
      relu_q        <= 1'b0;
      k             <= '0;
      pack          <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      wr_bank       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      beats_written <= '0;
      drop_err      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= (state_nxt == S_DONE);
      busy  <= (state_nxt == S_COLLECT) || (state_nxt == S_FLUSH);
      // A beat alongside the accepted start is still dropped, so set wins.
      drop_err <= (drop_err & ~accept) | (in_valid & (state != S_COLLECT));

      if (accept) begin
        waddr         <= base_addr;
        bc_q          <= beat_count;
        bank_q        <= bank_sel;
        relu_q        <= relu_en;
        k             <= '0;
        pack          <= '0;
        beats_written <= '0;
      end

      if (take) begin
        beats_written <= beats_written + 16'd1;
        if (word_end) begin
          wr_en   <= 1'b1;
          wr_addr <= waddr;
          wr_data <= pack_nxt;
          wr_bank <= bank_q;
          waddr   <= waddr + ADDR_WIDTH'(1);
          k       <= '0;
          pack    <= '0;
        end else begin
          k    <= k + KW'(1);
          pack <= pack_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_ofm_writeback.sv
// Directed bench for ofm_writeback (Tm=4, FW=16, 128-bit words, BPW=2).
module tb_ofm_writeback;
  logic         clk = 0;
  logic         rst, start, bank_sel, relu_en, in_valid;
  logic [7:0]   base_addr;
  logic [15:0]  beat_count;
  logic [63:0]  in_data;
  logic         wr_en, wr_bank, busy, done, drop_err;
  logic [7:0]   wr_addr;
  logic [127:0] wr_data;
  logic [15:0]  beats_written;

  int n_chk = 0, n_pass = 0, n_wr = 0;

  ofm_writeback dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .beat_count(beat_count), .bank_sel(bank_sel), .relu_en(relu_en),
    .in_valid(in_valid), .in_data(in_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_bank(wr_bank), .busy(busy), .done(done),
    .beats_written(beats_written), .drop_err(drop_err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (wr_en) n_wr++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock; inputs are then changed / outputs sampled 1ns later.
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic cmd(input logic [7:0] b, input logic [15:0] n, input logic bk, input logic rl);
    base_addr = b; beat_count = n; bank_sel = bk; relu_en = rl; start = 1;
    cyc();
    start = 0;
  endtask

  task automatic beat(input logic [63:0] d);
    in_valid = 1; in_data = d;
    cyc();
    in_valid = 0;
  endtask

  logic [63:0] b0, b1, b2, b3, neg, negr;
  int w0;

  initial begin
    b0 = 64'h0004_0003_0002_0001; b1 = 64'h1111_2222_3333_4444;
    b2 = 64'hAAAA_0BBB_0CCC_0DDD; b3 = 64'h0123_4567_89AB_CDEF;
    neg = 64'h8000_FFFF_0001_7FFF; negr = 64'h0000_0000_0001_7FFF;
    rst = 1; start = 0; base_addr = 0; beat_count = 0; bank_sel = 0;
    relu_en = 0; in_valid = 0; in_data = 0;
    cyc(); cyc();
    chk("rst_wr_en", wr_en, 0);   chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0); chk("rst_wr_bank", wr_bank, 0);
    chk("rst_busy", busy, 0);     chk("rst_done", done, 0);
    chk("rst_bw", beats_written, 0); chk("rst_drop", drop_err, 0);
    rst = 0; cyc();

    // Back-to-back 4 beats, base 0x10
    cmd(8'h10, 16'd4, 0, 0);
    chk("t1_busy", busy, 1);
    beat(b0); chk("t1_no_wr0", wr_en, 0);
    beat(b1);
    chk("t1_wr0_en", wr_en, 1); chk("t1_wr0_addr", wr_addr, 8'h10);
    chk("t1_wr0_data", wr_data, {b1, b0}); chk("t1_wr0_bank", wr_bank, 0);
    beat(b2); chk("t1_strobe_1cyc", wr_en, 0);
    beat(b3);
    chk("t1_wr1_en", wr_en, 1); chk("t1_wr1_addr", wr_addr, 8'h11);
    chk("t1_wr1_data", wr_data, {b3, b2}); chk("t1_done_early", done, 0);
    cyc();
    chk("t1_done", done, 1); chk("t1_busy_lo", busy, 0); chk("t1_bw", beats_written, 4);
    cyc();
    chk("t1_done_pulse", done, 0);

    // 3 beats with gaps; a start mid-tile must be ignored
    cmd(8'h20, 16'd3, 0, 0);
    cyc();
    beat(b0); cyc(); cyc();
    base_addr = 8'h99; beat_count = 16'd1; start = 1; cyc(); start = 0;
    beat(b1);
    chk("t2_wr0_addr", wr_addr, 8'h20); chk("t2_wr0_data", wr_data, {b1, b0});
    cyc();
    beat(b2);
    chk("t2_wr1_en", wr_en, 1); chk("t2_wr1_addr", wr_addr, 8'h21);
    chk("t2_wr1_partial", wr_data, {64'h0, b2}); chk("t2_bw", beats_written, 3);
    cyc(); chk("t2_done", done, 1);
    cyc();

    // ReLU on, then off
    cmd(8'h30, 16'd2, 0, 1);
    beat(neg); beat(neg);
    chk("t3_relu", wr_data, {negr, negr});
    cyc(); cyc();
    cmd(8'h31, 16'd1, 0, 0);
    beat(neg);
    chk("t3_norelu", wr_data, {64'h0, neg}); chk("t3_addr", wr_addr, 8'h31);
    cyc(); cyc();

    // Address wrap and bank 1
    cmd(8'hFF, 16'd4, 1, 0);
    beat(b0); beat(b1);
    chk("t4_addr_ff", wr_addr, 8'hFF); chk("t4_bank0", wr_bank, 1);
    beat(b2); beat(b3);
    chk("t4_addr_wrap", wr_addr, 8'h00); chk("t4_bank1", wr_bank, 1);
    cyc(); cyc();

    // Drop in IDLE, cleared by start; 5th beat dropped
    w0 = n_wr;
    beat(b0);
    chk("t5_drop_idle", drop_err, 1);
    cyc(); chk("t5_drop_no_wr", n_wr, w0);
    cmd(8'h40, 16'd4, 0, 0);
    chk("t5_drop_clr", drop_err, 0);
    in_valid = 1;
    in_data = b0; cyc(); in_data = b1; cyc(); in_data = b2; cyc();
    in_data = b3; cyc(); in_data = 64'hDEAD; cyc();
    in_valid = 0;
    chk("t5_drop_5th", drop_err, 1); chk("t5_bw", beats_written, 4);
    cyc();
    chk("t5_writes", n_wr, w0 + 2);
    cyc();
    cmd(8'h50, 16'd0, 0, 0);
    chk("t5_drop_clr2", drop_err, 0); chk("t5_zero_done", done, 1);
    cyc();

    // Reset mid-tile, then zero-length tile
    w0 = n_wr;
    cmd(8'h60, 16'd4, 1, 0);
    beat(b0);
    rst = 1; cyc(); rst = 0;
    chk("t6_busy", busy, 0); chk("t6_wr_en", wr_en, 0); chk("t6_wr_addr", wr_addr, 0);
    chk("t6_bw", beats_written, 0); chk("t6_done", done, 0);
    cyc(); cyc();
    cmd(8'h70, 16'd0, 0, 0);
    chk("t6_z_done", done, 1); chk("t6_z_busy", busy, 0);
    cyc();
    chk("t6_z_done_pulse", done, 0); chk("t6_no_wr", n_wr, w0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
